// File: rtl/lc3_ctrl_pkg.sv
// Shared LC-3 control definitions: operate-instruction opcodes, ALU function
// select encoding and the sequencer state type.
package lc3_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [2:0] NZP_ZERO = 3'b010;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } aluk_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ERR
  } seq_state_t;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Condition-code generator: classifies a 16-bit value as negative, zero or
// positive. Exactly one output bit is set for any input.
module lc3_nzp_gen
  import lc3_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [2:0]        nzp
);

  logic is_zero;

  assign is_zero = (value == '0);
  assign nzp     = {value[DATA_W-1], is_zero, ~value[DATA_W-1] & ~is_zero};

endmodule

// File: rtl/lc3_alu_sequencer.sv
// Sequences LC-3 ADD/AND/NOT through the external ALU and register file:
// accept, decode, execute, write back (4 cycles per instruction).
module lc3_alu_sequencer
  import lc3_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              instr_valid,
  input  logic [15:0]       IR,
  output logic              instr_ready,
  output logic [2:0]        SR1,
  output logic [2:0]        SR2,
  output logic              SR2MUX,
  output logic [15:0]       imm_sext,
  output logic [1:0]        ALUK,
  input  logic [15:0]       ALU_Out,
  output logic              LD_REG,
  output logic [2:0]        DR,
  output logic [15:0]       wb_data,
  output logic [2:0]        NZP,
  output logic              done,
  output logic              illegal
);

  seq_state_t  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  nzp_q, nzp_d;
  aluk_t       aluk_q, aluk_d;
  logic        sr2mux_q, sr2mux_d;
  logic        ld_reg_q, ld_reg_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        ready_q, ready_d;

  logic        dec_legal;
  aluk_t       dec_aluk;
  logic        dec_sr2mux;
  logic [2:0]  wb_nzp;

  lc3_nzp_gen u_nzp_gen (
    .value (wb_data_q),
    .nzp   (wb_nzp)
  );

  // Register addresses and immediate come straight from the held instruction.
  assign SR1      = ir_q[8:6];
  assign SR2      = ir_q[2:0];
  assign DR       = ir_q[11:9];
  assign imm_sext = {{11{ir_q[4]}}, ir_q[4:0]};

  always_comb begin
    dec_legal  = 1'b0;
    dec_aluk   = ALU_PASS;
    dec_sr2mux = 1'b0;
    unique case (ir_q[15:12])
      OP_ADD: begin
        dec_legal  = 1'b1;
        dec_aluk   = ALU_ADD;
        dec_sr2mux = ir_q[5];
      end
      OP_AND: begin
        dec_legal  = 1'b1;
        dec_aluk   = ALU_AND;
        dec_sr2mux = ir_q[5];
      end
      OP_NOT: begin
        // NOT is only encoded with all-ones in the low six bits.
        dec_legal  = (ir_q[5:0] == 6'b111111);
        dec_aluk   = ALU_NOT;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state values are what the registered outputs show in the next cycle.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wb_data_d = wb_data_q;
    nzp_d     = nzp_q;
    aluk_d    = ALU_PASS;
    sr2mux_d  = 1'b0;
    ld_reg_d  = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = IR;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d  = S_EXEC;
          aluk_d   = dec_aluk;
          sr2mux_d = dec_sr2mux;
        end else begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        wb_data_d = ALU_Out;
        state_d   = S_WB;
        ld_reg_d  = 1'b1;
        done_d    = 1'b1;
      end
      S_WB: begin
        nzp_d   = wb_nzp;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wb_data_q <= '0;
      nzp_q     <= NZP_ZERO;
      aluk_q    <= ALU_PASS;
      sr2mux_q  <= 1'b0;
      ld_reg_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wb_data_q <= wb_data_d;
      nzp_q     <= nzp_d;
      aluk_q    <= aluk_d;
      sr2mux_q  <= sr2mux_d;
      ld_reg_q  <= ld_reg_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign SR2MUX      = sr2mux_q;
  assign ALUK        = aluk_q;
  assign LD_REG      = ld_reg_q;
  assign wb_data     = wb_data_q;
  assign NZP         = nzp_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Bench for lc3_alu_sequencer: ALU and 8x16 register file models around the
// sequencer, directed instructions with a queue-based scoreboard.
module tb_lc3_alu_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        instr_ready;
  logic [2:0]  SR1, SR2, DR, NZP;
  logic        SR2MUX, LD_REG, done, illegal;
  logic [15:0] imm_sext, ALU_Out, wb_data;
  logic [1:0]  ALUK;

  lc3_alu_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .instr_valid (instr_valid),
    .IR          (IR),
    .instr_ready (instr_ready),
    .SR1         (SR1),
    .SR2         (SR2),
    .SR2MUX      (SR2MUX),
    .imm_sext    (imm_sext),
    .ALUK        (ALUK),
    .ALU_Out     (ALU_Out),
    .LD_REG      (LD_REG),
    .DR          (DR),
    .wb_data     (wb_data),
    .NZP         (NZP),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 Clk = ~Clk;

  // Register file and ALU models
  logic [15:0] rf [8];
  logic [15:0] alu_a, alu_b;
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = 3'd0;
  logic [15:0] pre_data = 16'h0000;

  always @(posedge Clk) begin
    if (LD_REG) rf[DR] <= wb_data;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  always_comb begin
    alu_a = rf[SR1];
    alu_b = SR2MUX ? imm_sext : rf[SR2];
    case (ALUK)
      2'b00:   ALU_Out = alu_a + alu_b;
      2'b01:   ALU_Out = alu_a & alu_b;
      2'b10:   ALU_Out = ~alu_a;
      default: ALU_Out = alu_a;
    endcase
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  typedef struct {
    bit          ill;
    logic [2:0]  dr;
    logic [15:0] data;
    logic [2:0]  nzp;
    logic [1:0]  aluk;
    bit          mux;
    int          acc;
    logic [15:0] ir;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit          nzp_pend = 1'b0;
  logic [2:0]  nzp_exp = 3'b000;

  // Monitor: pops an expectation whenever the DUT produces a result
  always @(negedge Clk) begin
    if (Reset) begin
      nzp_pend = 1'b0;
    end else begin
      chk("nzp_onehot", $countones(NZP), 1);
      if (nzp_pend) begin
        chk("nzp", NZP, nzp_exp);
        nzp_pend = 1'b0;
      end
      if (q.size() > 0 && !q[0].ill && cyc == q[0].acc + 1) begin
        chk("exec_aluk", ALUK, q[0].aluk);
        chk("exec_sr2mux", SR2MUX, q[0].mux);
      end
      if (done || illegal || LD_REG) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {done, illegal, LD_REG}, 3'b000);
        end else begin
          e = q.pop_front();
          if (e.ill) begin
            chk("illegal_flags", {done, illegal, LD_REG}, 3'b010);
            chk("illegal_latency", cyc - e.acc, 1);
          end else begin
            chk("wb_flags", {done, illegal, LD_REG}, 3'b101);
            chk("wb_latency", cyc - e.acc, 2);
            chk("wb_dr", DR, e.dr);
            chk("wb_data", wb_data, e.data);
          end
          $display("txn IR=%h ill=%0b DR=%0d wb_data=%h exp=%h", e.ir, illegal, DR, wb_data, e.data);
          nzp_exp  = e.nzp;
          nzp_pend = 1'b1;
        end
      end else if (q.size() > 0 && cyc > q[0].acc + 2) begin
        e = q.pop_front();
        chk("no_response", cyc - e.acc, e.ill ? 1 : 2);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge Clk);
    end
    chk("drain_queue", q.size(), 0);
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge Clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ir, input bit push, input bit ill,
                       input logic [2:0] dr, input logic [15:0] data,
                       input logic [2:0] nzp, input logic [1:0] aluk, input bit mux,
                       output int acc);
    exp_t n;
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", instr_ready, 1);
    IR = ir;
    instr_valid = 1'b1;
    @(posedge Clk);
    #1;
    acc = cyc;
    instr_valid = 1'b0;
    if (push) begin
      n.ill = ill; n.dr = dr; n.data = data; n.nzp = nzp;
      n.aluk = aluk; n.mux = mux; n.acc = acc; n.ir = ir;
      q.push_back(n);
    end
  endtask

  int acc;
  logic [15:0] chain_exp [5];

  initial begin
    chain_exp[0] = 16'h0004; chain_exp[1] = 16'h0003; chain_exp[2] = 16'h0002;
    chain_exp[3] = 16'h0001; chain_exp[4] = 16'h0000;

    // 1: reset state
    tick(3);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_nzp", NZP, 3'b010);
    chk("rst_ld_reg", LD_REG, 0);
    chk("rst_aluk", ALUK, 2'b11);
    chk("rst_done_illegal", {done, illegal}, 2'b00);
    chk("rst_wb_data", wb_data, 16'h0000);

    // 2: ADD R0,R1,R2
    poke(3'd1, 16'h0005);
    poke(3'd2, 16'h0003);
    issue(16'h1042, 1, 0, 3'd0, 16'h0008, 3'b001, 2'b00, 0, acc);

    // 3: back-to-back immediate adds, then a dependent decrement chain
    for (int i = 0; i < 5; i++)
      issue(16'h107F, 1, 0, 3'd0, 16'h0004, 3'b001, 2'b00, 1, acc);
    for (int i = 0; i < 5; i++)
      issue(16'h127F, 1, 0, 3'd1, chain_exp[i], (i == 4) ? 3'b010 : 3'b001, 2'b00, 1, acc);
    drain();
    poke(3'd1, 16'h7FFF);
    issue(16'h1061, 1, 0, 3'd0, 16'h8000, 3'b100, 2'b00, 1, acc);
    drain();
    poke(3'd2, 16'h8000);
    issue(16'h1482, 1, 0, 3'd2, 16'h0000, 3'b010, 2'b00, 0, acc);

    // 4: AND with zero, NOT, register AND
    drain();
    poke(3'd3, 16'h00F0);
    issue(16'h56E0, 1, 0, 3'd3, 16'h0000, 3'b010, 2'b01, 1, acc);
    issue(16'h9AFF, 1, 0, 3'd5, 16'hFFFF, 3'b100, 2'b10, 0, acc);
    drain();
    poke(3'd4, 16'h0F0F);
    issue(16'h5D05, 1, 0, 3'd6, 16'h0F0F, 3'b001, 2'b01, 0, acc);

    // 5: unsupported opcode and malformed NOT
    issue(16'h0000, 1, 1, 3'd0, 16'h0000, 3'b001, 2'b11, 0, acc);
    issue(16'h9A3E, 1, 1, 3'd0, 16'h0000, 3'b001, 2'b11, 0, acc);

    // 6: reset during execute abandons the write-back
    drain();
    poke(3'd1, 16'h0005);
    poke(3'd2, 16'h0003);
    issue(16'h1042, 0, 0, 3'd0, 16'h0000, 3'b000, 2'b00, 0, acc);
    while (cyc < acc + 1) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #2;
    chk("abort_ready", instr_ready, 1);
    chk("abort_nzp", NZP, 3'b010);
    chk("abort_ld_reg", LD_REG, 0);
    chk("abort_aluk", ALUK, 2'b11);
    Reset = 1'b0;
    tick(5);
    @(negedge Clk);
    chk("abort_r0_kept", rf[0], 16'h8000);

    // 6b: inputs wiggled while busy must not disturb the in-flight result
    issue(16'h1042, 1, 0, 3'd0, 16'h0008, 3'b001, 2'b00, 0, acc);
    IR = 16'h0000;
    instr_valid = 1'b1;
    while (cyc < acc + 1) @(negedge Clk);
    IR = 16'h5FFF;
    while (cyc < acc + 2) @(negedge Clk);
    instr_valid = 1'b0;
    IR = 16'h0000;

    drain();
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
